// File: rtl/accum_register.sv
// Accumulator register with load/add/sub/clear and multi-cycle 1-bit-per-cycle shifts.
// Flags and Q are registered; zero is decoded from Q.
module accum_register #(
   parameter int WIDTH    = 5,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] Data,
   output logic [WIDTH-1:0] Q,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             busy,
   output logic             done
);
   localparam int MSB = WIDTH - 1;
   localparam int CW  = (WIDTH < 5) ? WIDTH : 5;
   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [2:0] M_LOAD  = 3'd1;
   localparam logic [2:0] M_ADD   = 3'd2;
   localparam logic [2:0] M_SUB   = 3'd3;
   localparam logic [2:0] M_SHL   = 3'd4;
   localparam logic [2:0] M_SHR   = 3'd5;
   localparam logic [2:0] M_CLEAR = 3'd6;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [4:0]       cnt_q, cnt_d;
   logic             dir_q, dir_d;

   logic [WIDTH:0]   sum, diff;
   logic             add_ovf, sub_ovf;
   logic [4:0]       shamt;

   always_comb begin
      sum     = {1'b0, q_q} + {1'b0, Data};
      diff    = {1'b0, q_q} - {1'b0, Data};
      add_ovf = (q_q[MSB] == Data[MSB]) && (sum[MSB] != q_q[MSB]);
      sub_ovf = (q_q[MSB] != Data[MSB]) && (diff[MSB] != q_q[MSB]);
      // narrow widths still take the count from whatever low bits exist
      shamt = '0;
      for (int i = 0; i < CW; i++) shamt[i] = Data[i];
   end

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) begin
               done_d = 1'b1;
               case (mode)
                  M_LOAD: begin
                     q_d     = Data;
                     carry_d = 1'b0;
                     ovf_d   = 1'b0;
                  end
                  M_ADD: begin
                     carry_d = sum[WIDTH];
                     ovf_d   = add_ovf;
                     // overflow direction follows the sign of the original Q
                     q_d     = (SATURATE && add_ovf) ? (q_q[MSB] ? MAX_NEG : MAX_POS) : sum[MSB:0];
                  end
                  M_SUB: begin
                     carry_d = diff[WIDTH];
                     ovf_d   = sub_ovf;
                     q_d     = (SATURATE && sub_ovf) ? (q_q[MSB] ? MAX_NEG : MAX_POS) : diff[MSB:0];
                  end
                  M_SHL, M_SHR: begin
                     carry_d = 1'b0;
                     ovf_d   = 1'b0;
                     if (shamt != 5'd0) begin
                        state_d = SHIFT;
                        cnt_d   = shamt;
                        dir_d   = (mode == M_SHR);
                        done_d  = 1'b0;
                     end
                  end
                  M_CLEAR: begin
                     q_d     = '0;
                     carry_d = 1'b0;
                     ovf_d   = 1'b0;
                  end
                  default: ;
               endcase
            end
         end
         SHIFT: begin
            q_d   = dir_q ? {q_q[MSB], q_q[MSB:1]} : {q_q[MSB-1:0], 1'b0};
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == SHIFT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         q_q     <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= 5'd0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
      end
   end

   assign Q        = q_q;
   assign carry    = carry_q;
   assign overflow = ovf_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign zero     = (q_q == '0);
endmodule

// File: tb/tb_accum_register.sv
// Scoreboard bench: a wrapping and a saturating instance share stimulus; each done pops one expectation.
module tb_accum_register;
   localparam int W = 5;
   localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, ADD = 3'd2, SUB = 3'd3,
                          SHL = 3'd4, SHR = 3'd5, CLR = 3'd6, RSV = 3'd7;

   logic clk = 1'b0;
   logic reset, enable;
   logic [2:0] mode;
   logic [W-1:0] data;
   logic [W-1:0] q, q_s;
   logic carry, carry_s, ovf, ovf_s, zero, zero_s, busy, busy_s, done, done_s;

   always #5 clk = ~clk;

   accum_register #(.WIDTH(W), .SATURATE(1'b0)) dut (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode), .Data(data),
      .Q(q), .carry(carry), .overflow(ovf), .zero(zero), .busy(busy), .done(done));

   accum_register #(.WIDTH(W), .SATURATE(1'b1)) dut_s (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode), .Data(data),
      .Q(q_s), .carry(carry_s), .overflow(ovf_s), .zero(zero_s), .busy(busy_s), .done(done_s));

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] qs;
      logic         c;
      logic         o;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding command.
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_q", q, e.q);
            chk("done_carry", carry, e.c);
            chk("done_ovf", ovf, e.o);
            chk("done_q_sat", q_s, e.qs);
            chk("done_ovf_sat", ovf_s, e.o);
            chk("done_sat_sync", done_s, 1'b1);
         end
      end
   end

   task automatic push(input logic [W-1:0] eq, input logic [W-1:0] eqs,
                       input logic ec, input logic eo);
      exp_t e;
      e.q = eq; e.qs = eqs; e.c = ec; e.o = eo;
      sb.push_back(e);
   endtask

   task automatic cmd(input logic [2:0] m, input logic [W-1:0] d, input logic [W-1:0] eq,
                      input logic [W-1:0] eqs, input logic ec, input logic eo);
      @(negedge clk);
      enable = 1'b1; mode = m; data = d;
      push(eq, eqs, ec, eo);
      @(negedge clk);
      enable = 1'b0;
   endtask

   // Shift command; optionally throws a LOAD at the DUT while it is busy.
   task automatic shift_run(input logic [2:0] m, input int n, input logic [W-1:0] eq,
                            input bit inject, input string nm);
      int cyc, bcnt;
      cmd(m, W'(n), eq, eq, 1'b0, 1'b0);
      cyc = 1; bcnt = 0;
      while (!done && cyc < 64) begin
         bcnt += int'(busy);
         if (inject && cyc == 2) begin
            enable = 1'b1; mode = LOAD; data = 5'h05;
         end else begin
            enable = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      enable = 1'b0;
      chk({nm, "_latency"}, cyc, n + 1);
      chk({nm, "_busy_cycles"}, bcnt, n);
      chk({nm, "_busy_at_done"}, busy, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; enable = 1'b0; mode = HOLD; data = '0;
      repeat (2) @(negedge clk);
      chk("rst_q", q, 5'h00);
      chk("rst_carry", carry, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_zero", zero, 1'b1);
      reset = 1'b0;

      cmd(LOAD, 5'h0A, 5'h0A, 5'h0A, 1'b0, 1'b0);
      cmd(ADD,  5'h03, 5'h0D, 5'h0D, 1'b0, 1'b0);
      cmd(LOAD, 5'h0F, 5'h0F, 5'h0F, 1'b0, 1'b0);
      cmd(ADD,  5'h01, 5'h10, 5'h0F, 1'b0, 1'b1);
      cmd(HOLD, 5'h1F, 5'h10, 5'h0F, 1'b0, 1'b1);
      cmd(LOAD, 5'h10, 5'h10, 5'h10, 1'b0, 1'b0);
      cmd(SUB,  5'h01, 5'h0F, 5'h10, 1'b0, 1'b1);
      cmd(CLR,  5'h07, 5'h00, 5'h00, 1'b0, 1'b0);
      chk("clear_zero", zero, 1'b1);

      cmd(LOAD, 5'h02, 5'h02, 5'h02, 1'b0, 1'b0);
      cmd(SUB,  5'h03, 5'h1F, 5'h1F, 1'b1, 1'b0);
      chk("sub_zero", zero, 1'b0);
      cmd(ADD,  5'h01, 5'h00, 5'h00, 1'b1, 1'b0);
      chk("wrap_zero", zero, 1'b1);
      cmd(RSV,  5'h1F, 5'h00, 5'h00, 1'b1, 1'b0);

      cmd(LOAD, 5'h13, 5'h13, 5'h13, 1'b0, 1'b0);
      shift_run(SHR, 3, 5'h1E, 1'b1, "shr3");
      cmd(LOAD, 5'h07, 5'h07, 5'h07, 1'b0, 1'b0);
      shift_run(SHL, 7, 5'h00, 1'b0, "shl7");
      cmd(LOAD, 5'h02, 5'h02, 5'h02, 1'b0, 1'b0);
      cmd(SUB,  5'h03, 5'h1F, 5'h1F, 1'b1, 1'b0);
      shift_run(SHL, 0, 5'h1F, 1'b0, "shl0");
      cmd(LOAD, 5'h10, 5'h10, 5'h10, 1'b0, 1'b0);
      shift_run(SHR, 9, 5'h1F, 1'b0, "shr9");

      // back-to-back: second command presented in the cycle done is high
      @(negedge clk);
      enable = 1'b1; mode = LOAD; data = 5'h04;
      push(5'h04, 5'h04, 1'b0, 1'b0);
      @(negedge clk);
      chk("b2b_done", done, 1'b1);
      mode = ADD; data = 5'h01;
      push(5'h05, 5'h05, 1'b0, 1'b0);
      @(negedge clk);
      enable = 1'b0;

      // enable low: no command, Q untouched
      mode = LOAD; data = 5'h1B;
      repeat (2) @(negedge clk);
      chk("idle_q", q, 5'h05);

      // reset aborts a shift in progress
      @(negedge clk);
      enable = 1'b1; mode = SHL; data = 5'd4;
      @(negedge clk);
      enable = 1'b0;
      chk("abort_busy1", busy, 1'b1);
      @(negedge clk);
      chk("abort_busy2", busy, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_q", q, 5'h00);
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      reset = 1'b0;
      enable = 1'b1; mode = LOAD; data = 5'h05;
      push(5'h05, 5'h05, 1'b0, 1'b0);
      @(negedge clk);
      enable = 1'b0;
      chk("post_rst_load", q, 5'h05);

      repeat (8) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
